// File: rtl/dot_product_scheduler.sv
// Streaming signed 8x8 dot-product engine with command/element/result handshakes.
// Optional build macro DOT_PRODUCT_SATURATE_EN clamps the 16-bit result and raises io_res_ovf.
module dot_product_scheduler #(
  parameter int LEN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_cmd_valid,
  output logic             io_cmd_ready,
  input  logic [LEN_W-1:0] io_cmd_len,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [7:0]       io_in_a,
  input  logic [7:0]       io_in_w,
  output logic             io_res_valid,
  input  logic             io_res_ready,
  output logic [15:0]      io_res_data,
  output logic             io_res_ovf,
  output logic             io_busy
);

  localparam int ACC_W = 16 + LEN_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                   r_state;
  state_t                   w_nxt;
  logic                     r_cmd_ready;
  logic                     r_in_ready;
  logic                     r_res_valid;
  logic                     r_busy;
  logic [LEN_W-1:0]         r_cnt;
  logic signed [15:0]       r_prod_p1;
  logic                     r_vld_p1;
  logic signed [ACC_W-1:0]  r_acc_p2;

  logic                     w_cmd_fire;
  logic                     w_in_fire;
  logic signed [7:0]        w_a;
  logic signed [7:0]        w_w;
  logic signed [15:0]       w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic [16:0]              w_res;

`ifdef DOT_PRODUCT_SATURATE_EN
  localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] C_MIN = ACC_W'(-32768);

  // Returns {clamped, value}.
  function automatic logic [16:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > C_MAX)
      return {1'b1, 16'h7FFF};
    else if (v < C_MIN)
      return {1'b1, 16'h8000};
    else
      return {1'b0, v[15:0]};
  endfunction

  assign w_res = sat16(r_acc_p2);
`else
  assign w_res = {1'b0, r_acc_p2[15:0]};
`endif

  assign w_cmd_fire = io_cmd_valid & r_cmd_ready;
  assign w_in_fire  = io_in_valid & r_in_ready;
  assign w_a        = io_in_a;
  assign w_w        = io_in_w;
  assign w_prod     = w_a * w_w;
  assign w_prod_ext = {{LEN_W{r_prod_p1[15]}}, r_prod_p1};

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (io_cmd_valid) w_nxt = (io_cmd_len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (io_in_valid && r_cnt == LEN_W'(1)) w_nxt = S_DRAIN;
      S_DRAIN: w_nxt = S_DONE;
      S_DONE:  if (io_res_ready) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are registered alongside the state they decode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_cmd_ready <= (w_nxt == S_IDLE);
      r_in_ready  <= (w_nxt == S_RUN);
      r_res_valid <= (w_nxt == S_DONE);
      r_busy      <= (w_nxt != S_IDLE);
    end
  end

  // Stage p1 registers the product; stage p2 folds it into the accumulator.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_prod_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_acc_p2  <= '0;
    end else if (w_cmd_fire) begin
      r_cnt    <= io_cmd_len;
      r_vld_p1 <= 1'b0;
      r_acc_p2 <= '0;
    end else begin
      r_vld_p1 <= w_in_fire;
      if (w_in_fire) begin
        r_cnt     <= r_cnt - LEN_W'(1);
        r_prod_p1 <= w_prod;
      end
      if (r_vld_p1)
        r_acc_p2 <= r_acc_p2 + w_prod_ext;
    end
  end

  assign io_cmd_ready = r_cmd_ready;
  assign io_in_ready  = r_in_ready;
  assign io_res_valid = r_res_valid;
  assign io_busy      = r_busy;
  assign io_res_data  = r_res_valid ? w_res[15:0] : 16'h0000;
  assign io_res_ovf   = r_res_valid & w_res[16];

endmodule

// File: tb/tb_dot_product_scheduler.sv
// Randomized self-checking bench for dot_product_scheduler against a plain-arithmetic model.
// Honors DOT_PRODUCT_SATURATE_EN to select the expected result format.
module tb_dot_product_scheduler;
  localparam int LEN_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             io_cmd_valid;
  logic             io_cmd_ready;
  logic [LEN_W-1:0] io_cmd_len;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [7:0]       io_in_a;
  logic [7:0]       io_in_w;
  logic             io_res_valid;
  logic             io_res_ready;
  logic [15:0]      io_res_data;
  logic             io_res_ovf;
  logic             io_busy;

  int n_chk = 0;
  int n_bad = 0;
  int va[$];
  int vw[$];

  dot_product_scheduler #(.LEN_W(LEN_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_cmd_valid (io_cmd_valid),
    .io_cmd_ready (io_cmd_ready),
    .io_cmd_len   (io_cmd_len),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_a      (io_in_a),
    .io_in_w      (io_in_w),
    .io_res_valid (io_res_valid),
    .io_res_ready (io_res_ready),
    .io_res_data  (io_res_data),
    .io_res_ovf   (io_res_ovf),
    .io_busy      (io_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_result(input int sum, output logic [15:0] d, output logic o);
`ifdef DOT_PRODUCT_SATURATE_EN
    if (sum > 32767) begin
      d = 16'h7FFF; o = 1'b1;
    end else if (sum < -32768) begin
      d = 16'h8000; o = 1'b1;
    end else begin
      d = sum[15:0]; o = 1'b0;
    end
`else
    d = sum[15:0];
    o = 1'b0;
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, io_cmd_ready, 1);
    chk({tag, "_in_ready"},  io_in_ready,  0);
    chk({tag, "_res_valid"}, io_res_valid, 0);
    chk({tag, "_res_data"},  io_res_data,  0);
    chk({tag, "_res_ovf"},   io_res_ovf,   0);
    chk({tag, "_busy"},      io_busy,      0);
  endtask

  // Runs one vector from va/vw; gap_len idle cycles are inserted before element gap_idx.
  task automatic run_vec(input int len, input bit rnd_gaps, input int gap_idx,
                         input int gap_len, input int rdy_delay);
    int          sum;
    int          g;
    int          t;
    int          guard;
    logic [15:0] ed;
    logic        eo;
    sum   = 0;
    guard = 0;
    while (!io_cmd_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("idle_cmd_ready", io_cmd_ready, 1);
    io_cmd_valid = 1'b1;
    io_cmd_len   = len[LEN_W-1:0];
    step();
    io_cmd_valid = 1'b0;
    io_cmd_len   = LEN_W'($urandom);
    chk("busy_after_cmd", io_busy, 1);
    chk("cmd_ready_after_cmd", io_cmd_ready, 0);
    for (int i = 0; i < len; i++) begin
      g = (i == gap_idx) ? gap_len :
          (rnd_gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      for (int k = 0; k < g; k++) begin
        io_in_valid = 1'b0;
        io_in_a     = 8'($urandom);
        io_in_w     = 8'($urandom);
        step();
        chk("gap_in_ready", io_in_ready, 1);
        chk("gap_res_valid", io_res_valid, 0);
      end
      chk("run_in_ready", io_in_ready, 1);
      chk("run_res_valid", io_res_valid, 0);
      io_in_valid = 1'b1;
      t = va[i];
      io_in_a = t[7:0];
      t = vw[i];
      io_in_w = t[7:0];
      sum += va[i] * vw[i];
      step();
    end
    if (len > 0) begin
      // Junk offered while draining must be ignored.
      io_in_valid = 1'b1;
      io_in_a     = 8'($urandom);
      io_in_w     = 8'($urandom);
      chk("drain_in_ready", io_in_ready, 0);
      chk("drain_res_valid", io_res_valid, 0);
      step();
      io_in_valid = 1'b0;
    end
    expect_result(sum, ed, eo);
    chk("done_res_valid", io_res_valid, 1);
    chk("done_in_ready", io_in_ready, 0);
    chk("res_data", io_res_data, ed);
    chk("res_ovf", io_res_ovf, eo);
    io_res_ready = 1'b0;
    for (int k = 0; k < rdy_delay; k++) begin
      io_cmd_valid = 1'b1;
      step();
      chk("hold_res_valid", io_res_valid, 1);
      chk("hold_res_data", io_res_data, ed);
      chk("hold_res_ovf", io_res_ovf, eo);
      chk("hold_cmd_ready", io_cmd_ready, 0);
    end
    io_cmd_valid = 1'b1;
    io_res_ready = 1'b1;
    chk("done_cmd_ready", io_cmd_ready, 0);
    step();
    io_cmd_valid = 1'b0;
    io_res_ready = 1'b0;
    chk("post_res_valid", io_res_valid, 0);
    chk("post_busy", io_busy, 0);
    chk("post_cmd_ready", io_cmd_ready, 1);
  endtask

  initial begin
    reset        = 1'b1;
    io_cmd_valid = 1'b0;
    io_cmd_len   = '0;
    io_in_valid  = 1'b0;
    io_in_a      = '0;
    io_in_w      = '0;
    io_res_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;
    step();

    va = '{2, -4, 127};      vw = '{3, 5, -128};
    run_vec(3, 1'b0, -1, 0, 0);

    va = '{};                vw = '{};
    run_vec(0, 1'b0, -1, 0, 2);

    va = '{-128, -128, -128, -128}; vw = '{-128, -128, -128, -128};
    run_vec(4, 1'b0, -1, 0, 1);

    va = '{-128, -128, -128}; vw = '{127, 127, 127};
    run_vec(3, 1'b0, -1, 0, 0);

    va = '{10, -1};          vw = '{10, 1};
    run_vec(2, 1'b0, 1, 3, 5);

    // Reset in the middle of a vector discards it.
    io_cmd_valid = 1'b1;
    io_cmd_len   = LEN_W'(4);
    step();
    io_cmd_valid = 1'b0;
    io_in_valid  = 1'b1;
    io_in_a      = 8'd100;
    io_in_w      = 8'd100;
    step();
    step();
    io_in_valid  = 1'b0;
    chk("mid_in_ready", io_in_ready, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    step();
    reset = 1'b0;
    step();
    check_reset_outputs("after_rst");
    va = '{3};               vw = '{3};
    run_vec(1, 1'b0, -1, 0, 0);

    for (int n = 0; n < 25; n++) begin
      int len;
      len = (n == 24) ? 200 : int'($urandom_range(0, 12));
      va = '{};
      vw = '{};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          va.push_back(($urandom_range(0, 1) == 1) ? 127 : -128);
          vw.push_back(($urandom_range(0, 1) == 1) ? 127 : -128);
        end else begin
          va.push_back(int'($urandom_range(0, 255)) - 128);
          vw.push_back(int'($urandom_range(0, 255)) - 128);
        end
      end
      run_vec(len, 1'b1, -1, 0, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/dot_product_scheduler.md
DOT_PRODUCT_SCHEDULER -- requirements
Module: dot_product_scheduler

Interface
REQ-001 Parameter LEN_W, default 8, SHALL set the width of the vector-length field; the accumulator SHALL be ACC_W = 16+LEN_W bits.
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 io_cmd_valid  input  1  SHALL indicate that a command is offered.
REQ-005 io_cmd_ready  output  1  SHALL indicate that a command can be accepted.
REQ-006 io_cmd_len  input  LEN_W  SHALL give the unsigned element count N, 0..2^LEN_W-1.
REQ-007 io_in_valid  input  1  SHALL indicate that an element pair is offered.
REQ-008 io_in_ready  output  1  SHALL indicate that an element pair can be accepted.
REQ-009 io_in_a  input  8  SHALL carry the signed two's-complement activation.
REQ-010 io_in_w  input  8  SHALL carry the signed two's-complement weight.
REQ-011 io_res_valid  output  1  SHALL indicate that the result is available.
REQ-012 io_res_ready  input  1  SHALL indicate that the consumer takes the result.
REQ-013 io_res_data  output  16  SHALL carry the signed dot-product result.
REQ-014 io_res_ovf  output  1  SHALL flag saturation of the result.
REQ-015 io_busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, RUN, DRAIN, DONE.
REQ-017 io_cmd_ready SHALL be 1 only in IDLE; a transfer occurs when io_cmd_valid and io_cmd_ready are both 1 at the clock edge.
REQ-018 On command transfer, the accumulator and product-valid flag SHALL clear and the remaining count SHALL load N; next state SHALL be RUN if N>0, and DONE if N==0 (result 0, one cycle after the accept).
REQ-019 io_in_ready SHALL be 1 only in RUN; a pair transfers when io_in_valid and io_in_ready are both 1, and the remaining count SHALL decrement by one.
REQ-020 Each accepted pair SHALL be registered as a 16-bit signed product a*w (stage 1); a valid product SHALL be sign-extended and added to the ACC_W-bit accumulator on the following edge (stage 2).
REQ-021 When the last pair transfers (count==1), the FSM SHALL go RUN->DRAIN; DRAIN SHALL last exactly one cycle, then the FSM SHALL go DRAIN->DONE while the final product is accumulated.
REQ-022 io_res_valid SHALL be 1 exactly in DONE, first asserted 2 cycles after the cycle in which the last pair is accepted; io_res_data and io_res_ovf SHALL remain stable while io_res_valid=1 and io_res_ready=0.
REQ-023 DONE->IDLE SHALL occur on the edge where io_res_ready=1; a command offered in that same cycle SHALL NOT be accepted (cmd_ready=0 in DONE).
REQ-024 Gaps in io_in_valid SHALL stall RUN without loss or duplication of elements; io_in_valid outside RUN SHALL be ignored.
REQ-025 The accumulator SHALL never overflow internally (|sum| <= (2^LEN_W-1)*2^14 < 2^(ACC_W-1)).

Reset
REQ-026 Asserting reset at any time, including mid-RUN or DRAIN, SHALL force IDLE, clear the accumulator, count, product register and product-valid flag, and drive io_cmd_ready=1, io_in_ready=0, io_res_valid=0, io_res_data=0, io_res_ovf=0, io_busy=0; any partial vector SHALL be discarded.

Configuration
REQ-027 Macro DOT_PRODUCT_SATURATE_EN defined: io_res_data SHALL be the accumulator clamped to [-32768, 32767], and io_res_ovf SHALL be 1 when clamping occurred.
REQ-028 Macro DOT_PRODUCT_SATURATE_EN undefined: io_res_data SHALL be accumulator bits [15:0] (wrap-around), and io_res_ovf SHALL be tied to 0.

Verification
REQ-029 len=3, pairs (2,3),(-4,5),(127,-128), io_res_ready=1 -> io_res_data=0xC072 (-16270), io_res_ovf=0, io_res_valid high 2 cycles after the third accept.
REQ-030 len=0 -> io_res_valid=1 in the cycle after the command accept, data 0, io_in_ready never asserted.
REQ-031 len=4, four pairs (-128,-128) -> macro off: data 0x0000, ovf 0; macro on: data 0x7FFF, ovf 1.
REQ-032 len=2, (10,10) then a 3-cycle io_in_valid gap then (-1,1), io_res_ready low for 5 cycles -> data 99 held stable, io_cmd_ready=0 until the cycle after io_res_ready rises.
REQ-033 len=4, reset asserted after 2 accepts -> all outputs at reset values; after release, len=1 with (3,3) -> data 9.
